// File: rtl/frame_block_reader_if.sv
// frame_block_reader_if: burst read bus between the frame reader and the memory controller
// Ports (signals):
//   rd_burst_req        reader -> controller  burst read request
//   rd_burst_len        reader -> controller  burst length in words
//   rd_burst_addr       reader -> controller  burst base address
//   rd_burst_data_valid controller -> reader  read beat valid
//   rd_burst_data       controller -> reader  read beat data
//   rd_burst_finish     controller -> reader  burst complete pulse
interface frame_block_reader_if #(
    parameter int MEM_DATA_BITS = 32,
    parameter int ADDR_BITS     = 23,
    parameter int BURST_BITS    = 10
);
    logic                     rd_burst_req;
    logic [BURST_BITS-1:0]    rd_burst_len;
    logic [ADDR_BITS-1:0]     rd_burst_addr;
    logic                     rd_burst_data_valid;
    logic [MEM_DATA_BITS-1:0] rd_burst_data;
    logic                     rd_burst_finish;

    modport master (
        output rd_burst_req, rd_burst_len, rd_burst_addr,
        input  rd_burst_data_valid, rd_burst_data, rd_burst_finish
    );

    modport slave (
        input  rd_burst_req, rd_burst_len, rd_burst_addr,
        output rd_burst_data_valid, rd_burst_data, rd_burst_finish
    );
endinterface

// File: rtl/frame_block_reader.sv
// frame_block_reader: walks stored frames block by block, issuing fixed-length burst reads
// and handing each completed block to a downstream sender.
// Ports:
//   mem_clk, rst     clock, synchronous active-high reset
//   enable           frames valid; sampled only between blocks
//   loop_en          wrap to frame 0 after the last frame instead of stopping
//   mem              burst read bus (master side)
//   block_ready      block fully read; held until consumer_done
//   consumer_done    sender finished the current block
//   frame_idx        current frame, block_idx current block within the frame
//   frame_done       one-cycle pulse when the last block of a frame is handed off
//   all_done         sticky; last block of last frame handed off with loop_en=0
//   beat_err         sticky; some burst finished with a wrong beat count
module frame_block_reader #(
    parameter int MEM_DATA_BITS    = 32,
    parameter int ADDR_BITS        = 23,
    parameter int BURST_BITS       = 10,
    parameter int BURST_SIZE       = 128,
    parameter int BURSTS_PER_BLOCK = 2,
    parameter int BLOCK_STRIDE     = 240,
    parameter int BLOCKS_PER_FRAME = 1280,
    parameter int FRAME_COUNT      = 3,
    parameter int FRAME_STRIDE     = 2073600,
    parameter int FRAME_BITS       = 2,
    parameter int CNT_BITS         = 16
) (
    input  logic                  mem_clk,
    input  logic                  rst,
    input  logic                  enable,
    input  logic                  loop_en,
    frame_block_reader_if.master  mem,
    output logic                  block_ready,
    input  logic                  consumer_done,
    output logic [FRAME_BITS-1:0] frame_idx,
    output logic [CNT_BITS-1:0]   block_idx,
    output logic                  frame_done,
    output logic                  all_done,
    output logic                  beat_err
);
    localparam int BI_BITS = BURSTS_PER_BLOCK > 1 ? $clog2(BURSTS_PER_BLOCK) : 1;
    // room for BURST_SIZE+1 so an over-long burst saturates above the expected count
    localparam int BC_BITS = $clog2(BURST_SIZE + 2);

    typedef enum logic [2:0] {IDLE, REQ, BURST, HANDOFF, DONE} state_t;

    state_t               state;
    logic [BI_BITS-1:0]   burst_idx;
    logic [BC_BITS-1:0]   beat_cnt;
    logic [BC_BITS:0]     beats_now;

    // block base address at full precision, truncated to the bus width
    function automatic logic [ADDR_BITS-1:0] block_addr(input logic [FRAME_BITS-1:0] f,
                                                        input logic [CNT_BITS-1:0] b);
        logic [63:0] a;
        a = 64'(f) * 64'(FRAME_STRIDE) + 64'(b) * 64'(BLOCK_STRIDE);
        return a[ADDR_BITS-1:0];
    endfunction

    assign mem.rd_burst_len = BURST_BITS'(BURST_SIZE);
    // count including a beat arriving in the same cycle as finish
    assign beats_now = {1'b0, beat_cnt} + (BC_BITS+1)'(mem.rd_burst_data_valid);

    always_ff @(posedge mem_clk) begin
        if (rst) begin
            state             <= IDLE;
            mem.rd_burst_req  <= 1'b0;
            mem.rd_burst_addr <= '0;
            burst_idx         <= '0;
            beat_cnt          <= '0;
            block_ready       <= 1'b0;
            frame_idx         <= '0;
            block_idx         <= '0;
            frame_done        <= 1'b0;
            all_done          <= 1'b0;
            beat_err          <= 1'b0;
        end else begin
            frame_done <= 1'b0;
            case (state)
                IDLE: if (enable) begin
                    mem.rd_burst_req  <= 1'b1;
                    mem.rd_burst_addr <= block_addr(frame_idx, block_idx);
                    beat_cnt          <= '0;
                    state             <= REQ;
                end
                REQ, BURST: begin
                    if (mem.rd_burst_data_valid)
                        beat_cnt <= (beat_cnt > BC_BITS'(BURST_SIZE)) ? beat_cnt : beat_cnt + BC_BITS'(1);
                    if (mem.rd_burst_data_valid || mem.rd_burst_finish) begin
                        mem.rd_burst_req <= 1'b0;
                        state            <= BURST;
                    end
                    // a finish also overrides the request drop above when re-requesting
                    if (mem.rd_burst_finish) begin
                        if (beats_now != (BC_BITS+1)'(BURST_SIZE))
                            beat_err <= 1'b1;
                        beat_cnt <= '0;
                        if (burst_idx != BI_BITS'(BURSTS_PER_BLOCK - 1)) begin
                            burst_idx         <= burst_idx + BI_BITS'(1);
                            mem.rd_burst_req  <= 1'b1;
                            mem.rd_burst_addr <= mem.rd_burst_addr + ADDR_BITS'(BURST_SIZE);
                            state             <= REQ;
                        end else begin
                            burst_idx   <= '0;
                            block_ready <= 1'b1;
                            state       <= HANDOFF;
                        end
                    end
                end
                HANDOFF: if (consumer_done) begin
                    block_ready <= 1'b0;
                    state       <= IDLE;
                    if (block_idx == CNT_BITS'(BLOCKS_PER_FRAME - 1)) begin
                        block_idx  <= '0;
                        frame_done <= 1'b1;
                        if (frame_idx != FRAME_BITS'(FRAME_COUNT - 1))
                            frame_idx <= frame_idx + FRAME_BITS'(1);
                        else if (loop_en)
                            frame_idx <= '0;
                        else begin
                            all_done <= 1'b1;
                            state    <= DONE;
                        end
                    end else begin
                        block_idx <= block_idx + CNT_BITS'(1);
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_frame_block_reader.sv
// tb_frame_block_reader: randomized controller/consumer stimulus against an arithmetic address model
module tb_frame_block_reader;
    localparam int MDB = 32;
    localparam int AB  = 23;
    localparam int BB  = 10;
    localparam int BSZ = 8;
    localparam int BPB = 2;
    localparam int BS  = 240;
    localparam int BPF = 3;
    localparam int FC  = 3;
    localparam int FS  = 8388500;
    localparam int FB  = 2;
    localparam int CB  = 16;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic enable = 1'b0;
    logic loop_en = 1'b0;
    logic consumer_done = 1'b0;
    logic block_ready, frame_done, all_done, beat_err;
    logic [FB-1:0] frame_idx;
    logic [CB-1:0] block_idx;

    int total = 0;
    int bad = 0;
    bit exp_err;
    int fd_cnt;

    frame_block_reader_if #(.MEM_DATA_BITS(MDB), .ADDR_BITS(AB), .BURST_BITS(BB)) mem ();

    frame_block_reader #(
        .MEM_DATA_BITS(MDB), .ADDR_BITS(AB), .BURST_BITS(BB), .BURST_SIZE(BSZ),
        .BURSTS_PER_BLOCK(BPB), .BLOCK_STRIDE(BS), .BLOCKS_PER_FRAME(BPF),
        .FRAME_COUNT(FC), .FRAME_STRIDE(FS), .FRAME_BITS(FB), .CNT_BITS(CB)
    ) dut (
        .mem_clk(clk), .rst(rst), .enable(enable), .loop_en(loop_en), .mem(mem),
        .block_ready(block_ready), .consumer_done(consumer_done),
        .frame_idx(frame_idx), .block_idx(block_idx), .frame_done(frame_done),
        .all_done(all_done), .beat_err(beat_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // k-th block handed off since reset, u-th burst in it
    function automatic logic [63:0] exp_addr(input int k, input int u);
        logic [63:0] a;
        a = 64'((k / BPF) % FC) * 64'(FS) + 64'(k % BPF) * 64'(BS) + 64'(u) * 64'(BSZ);
        return a % (64'd1 << AB);
    endfunction

    task automatic wait_req(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (mem.rd_burst_req) begin
                ok = 1'b1;
                return;
            end
            @(negedge clk);
        end
        chk("req_timeout", 64'(0), 64'(1));
    endtask

    task automatic burst(input int k, input int u, input bit short_b);
        bit ok;
        bit same;
        int n;
        n = short_b ? BSZ - 1 : BSZ;
        same = 1'($urandom_range(0, 1));
        wait_req(ok);
        if (!ok) return;
        chk("addr", 64'(mem.rd_burst_addr), exp_addr(k, u));
        chk("len", 64'(mem.rd_burst_len), 64'(BSZ));
        repeat ($urandom_range(0, 2)) begin
            @(negedge clk);
            chk("req_hold", 64'(mem.rd_burst_req), 64'(1));
        end
        for (int i = 0; i < n; i++) begin
            mem.rd_burst_data_valid = 1'b1;
            mem.rd_burst_data = $urandom;
            mem.rd_burst_finish = same && (i == n - 1);
            enable = 1'($urandom_range(0, 1));
            @(negedge clk);
            mem.rd_burst_data_valid = 1'b0;
            mem.rd_burst_finish = 1'b0;
            if (i == 0) chk("req_drop", 64'(mem.rd_burst_req), 64'(0));
            if (i < n - 1) repeat ($urandom_range(0, 1)) @(negedge clk);
        end
        if (!same) begin
            repeat ($urandom_range(0, 2)) @(negedge clk);
            mem.rd_burst_finish = 1'b1;
            @(negedge clk);
            mem.rd_burst_finish = 1'b0;
        end
        if (short_b) exp_err = 1'b1;
        enable = 1'b1;
    endtask

    task automatic block(input int k, input bit short_b, input bit last_stop);
        for (int u = 0; u < BPB; u++) burst(k, u, short_b && u == 0);
        chk("block_ready", 64'(block_ready), 64'(1));
        chk("beat_err", 64'(beat_err), 64'(exp_err));
        repeat ($urandom_range(0, 3)) begin
            @(negedge clk);
            chk("ready_hold", 64'(block_ready), 64'(1));
        end
        consumer_done = 1'b1;
        @(negedge clk);
        consumer_done = 1'b0;
        chk("ready_clr", 64'(block_ready), 64'(0));
        chk("block_idx", 64'(block_idx), 64'((k + 1) % BPF));
        if (!last_stop) chk("frame_idx", 64'(frame_idx), 64'(((k + 1) / BPF) % FC));
        chk("frame_done", 64'(frame_done), 64'((k + 1) % BPF == 0));
        chk("all_done", 64'(all_done), 64'(last_stop));
        chk("gap_req", 64'(mem.rd_burst_req), 64'(0));
        if (frame_done) fd_cnt++;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog total=%0d bad=%0d", total, bad);
        $fatal(1, "timeout");
    end

    initial begin
        bit ok;
        mem.rd_burst_data_valid = 1'b0;
        mem.rd_burst_finish = 1'b0;
        mem.rd_burst_data = '0;
        repeat (2) @(negedge clk);
        chk("rst_req", 64'(mem.rd_burst_req), 64'(0));
        chk("rst_len", 64'(mem.rd_burst_len), 64'(BSZ));
        chk("rst_addr", 64'(mem.rd_burst_addr), 64'(0));
        chk("rst_ready", 64'(block_ready), 64'(0));
        chk("rst_idx", 64'({frame_idx, block_idx}), 64'(0));
        chk("rst_flags", 64'({frame_done, all_done, beat_err}), 64'(0));
        rst = 1'b0;
        repeat (5) @(negedge clk);
        chk("idle_no_req", 64'(mem.rd_burst_req), 64'(0));

        enable = 1'b1;
        wait_req(ok);
        chk("pre_rst_addr", 64'(mem.rd_burst_addr), 64'(0));
        mem.rd_burst_data_valid = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        mem.rd_burst_finish = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        enable = 1'b0;
        repeat (3) begin
            @(negedge clk);
            chk("stray_no_req", 64'(mem.rd_burst_req), 64'(0));
        end
        mem.rd_burst_data_valid = 1'b0;
        mem.rd_burst_finish = 1'b0;
        @(negedge clk);
        chk("mid_rst_addr", 64'(mem.rd_burst_addr), 64'(0));
        chk("mid_rst_idx", 64'({frame_idx, block_idx}), 64'(0));
        chk("mid_rst_flags", 64'({block_ready, frame_done, all_done, beat_err}), 64'(0));

        exp_err = 1'b0;
        fd_cnt = 0;
        loop_en = 1'b0;
        enable = 1'b1;
        for (int k = 0; k < BPF * FC; k++) block(k, k == 4, k == BPF * FC - 1);
        chk("frame_done_cnt", 64'(fd_cnt), 64'(FC));
        repeat (20) begin
            mem.rd_burst_data_valid = 1'($urandom_range(0, 1));
            mem.rd_burst_finish = 1'($urandom_range(0, 1));
            @(negedge clk);
            chk("done_no_req", 64'(mem.rd_burst_req), 64'(0));
        end
        mem.rd_burst_data_valid = 1'b0;
        mem.rd_burst_finish = 1'b0;
        chk("done_sticky", 64'({all_done, beat_err}), 64'(3));

        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("rst2_flags", 64'({all_done, beat_err}), 64'(0));
        exp_err = 1'b0;
        loop_en = 1'b1;
        enable = 1'b1;
        for (int k = 0; k <= BPF * FC; k++) block(k, 1'b0, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
